decode_issue: RTL and testbench
===============================

// Module: decode_issue
// PURPOSE
//  Stage directly downstream of fetch. Takes fetch's 64-bit two-slot bundle plus PC and registers it in a hold buffer.
//  Splits the bundle into slot0 = inst[63:32] and slot1 = inst[31:0], extracts fields and issues them to execute.
//  Detects load-use and intra-bundle hazards and drives fetch's interlock input. Flushes on branch_flag from execute.
// PARAMETERS
//  LOAD_LAT  2  cycles after issue before a load's rd can be read by a dependent instruction (1..4)
// PORTS
//  clk             in   1   clock, all state on posedge
//  rst             in   1   synchronous reset, active-high
//  pc_in           in   32  pc_to_the_next from fetch
//  inst_in         in   64  inst_to_the_next from fetch
//  branch_flag     in   1   execute resolved a taken branch; squash this stage
//  interlock       out  1   to fetch; combinational from internal state only, with no path from pc_in/inst_in
//  issue_pc        out  32  PC of the issued bundle
//  issue_valid     out  2   per-slot valid; [1]=slot0, [0]=slot1
//  issue_op        out  12  {op0[5:0], op1[5:0]}
//  issue_rd        out  10  {rd0, rd1}
//  issue_rs1       out  10  {rs1_0, rs1_1}
//  issue_rs2       out  10  {rs2_0, rs2_1}
//  issue_imm       out  32  {imm0[15:0], imm1[15:0]}
// BEHAVIOUR
//  - Field layout per 32-bit slot:
//      [31:26] op, [25:21] rd, [20:16] rs1, [15:11] rs2, [15:0] imm.
//  - A slot is NOP when [31:29]==3'b111. NOP slots have valid=0 and every field 0.
//  - Usage rules for a non-NOP slot:
//      rs1 is always read.
//      rs2 is read only when op[5:4]==2'b00.
//      rd is written unless op[5:3]==3'b011 (store/branch class).
//      Load means op==OP_LD.
//      Register 0 is never a hazard source and is never tracked.
//  - Hold buffer HB {pc, inst}:
//      Loads pc_in/inst_in each posedge when interlock==0.
//      Holds its value when interlock==1; inputs are ignored, fetch supplies NOP meanwhile.
//  - Latency: a bundle sampled into HB at edge t is on issue_* after edge t+1 if no stall occurs. issue_* are registered.
//  - Scoreboard: a LOAD_LAT-deep shift of {v0,rd0,v1,rd1}.
//      Each edge it pushes the load rds issued that edge and ages the rest.
//      pending(r) = r!=0 && r matches any valid entry.
//  - Stall causes, evaluated on HB:
//      LU (load-use): any still-unissued slot reads a pending reg.
//      ID (intra-bundle): slot1 reads slot0's written rd, or both slots write the same rd != 0.
//  - FSM:
//      RUN:
//        LU: issue a NOP bundle, interlock=1, HB held.
//        else ID: issue slot0 with slot1 as NOP, interlock=1, go to SPLIT.
//        else: issue both slots, interlock=0.
//      SPLIT:
//        LU on slot1: issue NOP, interlock=1.
//        else: issue slot1 only (slot0 as NOP), interlock=0, go to RUN.
//  - branch_flag=1 at an edge:
//      HB <= {0, NOP bundle}; issue_* <= NOP bundle with issue_pc=0; FSM <= RUN.
//      interlock is 0 in the following cycle.
//      The scoreboard is not cleared; stale entries cost only conservative stalls.
//  - branch_flag together with a stall: the flush wins.
//  - Reset (rst=1 at posedge), including mid-split or mid-stall:
//      HB <= NOP bundle, pc 0; issue_* all 0; scoreboard cleared; FSM <= RUN; interlock=0.
// STRUCTURE
//  - cpu_pkg holds:
//      NOP_INST = {3'b111, 29'b0} and NOP_BUNDLE.
//      The opcode constant OP_LD.
//      Field-position localparams.
//      Functions uses_rs2(op), writes_rd(op), is_nop(inst).
//  - One sub-module: load_scoreboard.
//      Shift register of depth LOAD_LAT.
//      Push ports for 2 rds; query ports for 4 sources; returns 4 pending bits.
//  - decode_issue holds HB, the 2-state FSM, field extraction and the issue registers.
// TESTING
//  - Reset: hold rst 2 cycles -> issue_valid=0, issue_pc=0, interlock=0. Then feed pc 5 with two ADDs -> issue_valid=2'b11 and issue_pc=5 two edges later.
//  - Load-use, LOAD_LAT=2:
//      Cycle n: bundle {LD r3, NOP}. Cycle n+1: bundle {ADD r4=r3+r1, NOP}.
//      -> ADD issues exactly 2 edges after the LD issues; interlock high for the intervening cycle(s); no bundle lost.
//  - Intra-bundle: {ADD r2=r1+r1, ADD r5=r2+r0} at pc 8
//      -> edge1: valid=2'b10; edge2: valid=2'b01, issue_pc=8; interlock high for exactly 1 cycle.
//  - Flush in SPLIT: assert branch_flag in the cycle after the split starts
//      -> slot1 is never issued, issue_valid=0, interlock=0 next cycle, FSM back in RUN.
//  - r0 exemption: {LD r0, ...} followed by {ADD reads r0} -> no stall.
//  - Mid-stall reset: rst during a load-use stall -> all outputs 0 next edge; the scoreboard is empty (the next bundle reading r3 issues without a stall).

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants, field positions and slot-decode helpers for the decode/issue stage.
package cpu_pkg;

    localparam logic [31:0] NOP_INST   = {3'b111, 29'b0};
    localparam logic [63:0] NOP_BUNDLE = {NOP_INST, NOP_INST};

    localparam logic [5:0] OP_LD = 6'b010000;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RD_MSB  = 25;
    localparam int RD_LSB  = 21;
    localparam int RS1_MSB = 20;
    localparam int RS1_LSB = 16;
    localparam int RS2_MSB = 15;
    localparam int RS2_LSB = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_SPLIT = 1'b1
    } state_t;

    typedef struct packed {
        logic        valid;
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [15:0] imm;
        logic        rd_w;
        logic        rs2_r;
        logic        is_ld;
    } slot_t;

    typedef struct packed {
        logic       v0;
        logic [4:0] rd0;
        logic       v1;
        logic [4:0] rd1;
    } sb_entry_t;

    function automatic logic uses_rs2(input logic [5:0] op);
        return op[5:4] == 2'b00;
    endfunction

    function automatic logic writes_rd(input logic [5:0] op);
        return op[5:3] != 3'b011;
    endfunction

    function automatic logic is_nop(input logic [31:0] inst);
        return inst[31:29] == 3'b111;
    endfunction

    // A NOP slot decodes to all-zero so it can be issued as-is.
    function automatic slot_t decode_slot(input logic [31:0] inst);
        slot_t s;
        s = '0;
        if (!is_nop(inst)) begin
            s.valid = 1'b1;
            s.op    = inst[OP_MSB:OP_LSB];
            s.rd    = inst[RD_MSB:RD_LSB];
            s.rs1   = inst[RS1_MSB:RS1_LSB];
            s.rs2   = inst[RS2_MSB:RS2_LSB];
            s.imm   = inst[IMM_MSB:IMM_LSB];
            s.rd_w  = writes_rd(s.op);
            s.rs2_r = uses_rs2(s.op);
            s.is_ld = (s.op == OP_LD);
        end
        return s;
    endfunction

endpackage

// File: rtl/decode_issue_load_scoreboard.sv
// Tracks destination registers of recently issued loads and flags sources that are not yet readable.
module load_scoreboard
    import cpu_pkg::*;
#(
    parameter int LOAD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  push_valid,
    input  logic [9:0]  push_rd,
    input  logic [19:0] query_reg,
    output logic [3:0]  pending
);

    // A load issued at edge e can feed a consumer issued at edge e+LOAD_LAT,
    // so its rd only has to stay visible for LOAD_LAT-1 cycles.
    localparam int   DEPTH  = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1;
    localparam logic ACTIVE = (LOAD_LAT > 1);

    sb_entry_t sb [DEPTH];
    logic [4:0] r;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                sb[i] <= '0;
            end
        end else begin
            sb[0] <= '{v0:  push_valid[1] && (push_rd[9:5] != 5'd0),
                       rd0: push_rd[9:5],
                       v1:  push_valid[0] && (push_rd[4:0] != 5'd0),
                       rd1: push_rd[4:0]};
            for (int i = 1; i < DEPTH; i++) begin
                sb[i] <= sb[i-1];
            end
        end
    end

    always_comb begin
        pending = '0;
        r       = '0;
        for (int q = 0; q < 4; q++) begin
            r = query_reg[q*5 +: 5];
            for (int i = 0; i < DEPTH; i++) begin
                if ((r != 5'd0) &&
                    ((sb[i].v0 && (sb[i].rd0 == r)) || (sb[i].v1 && (sb[i].rd1 == r)))) begin
                    pending[q] = 1'b1;
                end
            end
        end
        pending = pending & {4{ACTIVE}};
    end

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: hold buffer, hazard detection, RUN/SPLIT issue FSM and registered issue outputs.
//   state    | meaning
//   ST_RUN   | both HB slots unissued; issue both, stall, or issue slot0 and split
//   ST_SPLIT | slot0 already issued; issue slot1 once it is hazard-free
module decode_issue
    import cpu_pkg::*;
#(
    parameter int LOAD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic [63:0] inst_in,
    input  logic        branch_flag,
    output logic        interlock,
    output logic [31:0] issue_pc,
    output logic [1:0]  issue_valid,
    output logic [11:0] issue_op,
    output logic [9:0]  issue_rd,
    output logic [9:0]  issue_rs1,
    output logic [9:0]  issue_rs2,
    output logic [31:0] issue_imm
);

    logic [31:0] hb_pc;
    logic [63:0] hb_inst;
    state_t      state, state_nx;
    slot_t       s0, s1;
    logic [3:0]  pend;
    logic        lu0, lu1, id_hz;
    logic        sel0, sel1;
    logic [1:0]  push_valid;

    assign s0 = decode_slot(hb_inst[63:32]);
    assign s1 = decode_slot(hb_inst[31:0]);

    load_scoreboard #(.LOAD_LAT(LOAD_LAT)) u_sb (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .push_rd    ({s0.rd, s1.rd}),
        .query_reg  ({s0.rs1, s0.rs2, s1.rs1, s1.rs2}),
        .pending    (pend)
    );

    assign lu0 = s0.valid && (pend[3] || (s0.rs2_r && pend[2]));
    assign lu1 = s1.valid && (pend[1] || (s1.rs2_r && pend[0]));

    assign id_hz = s0.valid && s1.valid && s0.rd_w && (s0.rd != 5'd0) &&
                   ((s1.rs1 == s0.rd) ||
                    (s1.rs2_r && (s1.rs2 == s0.rd)) ||
                    (s1.rd_w && (s1.rd == s0.rd)));

    // A flush squashes whatever this edge would issue, so nothing enters the scoreboard.
    assign push_valid = {sel0 && s0.is_ld, sel1 && s1.is_ld} & {2{~branch_flag}};

    always_comb begin
        state_nx  = state;
        sel0      = 1'b0;
        sel1      = 1'b0;
        interlock = 1'b0;
        case (state)
            ST_RUN: begin
                if (lu0 || lu1) begin
                    interlock = 1'b1;
                end else if (id_hz) begin
                    sel0      = 1'b1;
                    interlock = 1'b1;
                    state_nx  = ST_SPLIT;
                end else begin
                    sel0 = 1'b1;
                    sel1 = 1'b1;
                end
            end
            ST_SPLIT: begin
                if (lu1) begin
                    interlock = 1'b1;
                end else begin
                    sel1     = 1'b1;
                    state_nx = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || branch_flag) begin
            hb_pc       <= '0;
            hb_inst     <= NOP_BUNDLE;
            state       <= ST_RUN;
            issue_pc    <= '0;
            issue_valid <= '0;
            issue_op    <= '0;
            issue_rd    <= '0;
            issue_rs1   <= '0;
            issue_rs2   <= '0;
            issue_imm   <= '0;
        end else begin
            if (!interlock) begin
                hb_pc   <= pc_in;
                hb_inst <= inst_in;
            end
            state       <= state_nx;
            issue_pc    <= hb_pc;
            issue_valid <= {sel0 && s0.valid, sel1 && s1.valid};
            issue_op    <= {sel0 ? s0.op  : 6'd0,  sel1 ? s1.op  : 6'd0};
            issue_rd    <= {sel0 ? s0.rd  : 5'd0,  sel1 ? s1.rd  : 5'd0};
            issue_rs1   <= {sel0 ? s0.rs1 : 5'd0,  sel1 ? s1.rs1 : 5'd0};
            issue_rs2   <= {sel0 ? s0.rs2 : 5'd0,  sel1 ? s1.rs2 : 5'd0};
            issue_imm   <= {sel0 ? s0.imm : 16'd0, sel1 ? s1.imm : 16'd0};
        end
    end

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: reset, dual issue, load-use, intra-bundle splits, flush and r0 rules.
module tb_decode_issue;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic [63:0] inst_in;
    logic        branch_flag;
    logic        interlock;
    logic [31:0] issue_pc;
    logic [1:0]  issue_valid;
    logic [11:0] issue_op;
    logic [9:0]  issue_rd;
    logic [9:0]  issue_rs1;
    logic [9:0]  issue_rs2;
    logic [31:0] issue_imm;

    int checks   = 0;
    int failures = 0;

    localparam logic [5:0] ADD = 6'h01;
    localparam logic [5:0] LD  = 6'h10;
    localparam logic [5:0] ST  = 6'h18;

    decode_issue #(.LOAD_LAT(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_in       (pc_in),
        .inst_in     (inst_in),
        .branch_flag (branch_flag),
        .interlock   (interlock),
        .issue_pc    (issue_pc),
        .issue_valid (issue_valid),
        .issue_op    (issue_op),
        .issue_rd    (issue_rd),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_imm   (issue_imm)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
        return {op, rd, rs1, rs2, 11'd0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] i0, input logic [31:0] i1);
        pc_in   = pc;
        inst_in = {i0, i1};
    endtask

    initial begin
        rst = 1'b1; branch_flag = 1'b0;
        drive(32'd0, NOP_INST, NOP_INST);
        tick(); tick();
        check("rst_valid", 64'(issue_valid), 64'd0);
        check("rst_pc", 64'(issue_pc), 64'd0);
        check("rst_interlock", 64'(interlock), 64'd0);

        // dual issue
        rst = 1'b0;
        drive(32'd5, enc(ADD, 5'd1, 5'd2, 5'd3), enc(ADD, 5'd4, 5'd5, 5'd6));
        tick();
        drive(32'd0, NOP_INST, NOP_INST);
        tick();
        check("dual_valid", 64'(issue_valid), 64'h3);
        check("dual_pc", 64'(issue_pc), 64'd5);
        check("dual_op", 64'(issue_op), 64'h041);
        check("dual_rd_rs", {34'd0, issue_rd, issue_rs1, issue_rs2},
              {34'd0, 5'd1, 5'd4, 5'd2, 5'd5, 5'd3, 5'd6});
        check("dual_imm", 64'(issue_imm), 64'h1800_3000);
        tick();
        check("nop_valid", 64'(issue_valid), 64'd0);

        // load-use
        drive(32'd16, enc(LD, 5'd3, 5'd1, 5'd0), NOP_INST);
        tick();
        drive(32'd20, enc(ADD, 5'd4, 5'd3, 5'd1), NOP_INST);
        tick();
        check("lu_ld_valid", 64'(issue_valid), 64'h2);
        check("lu_ld_rd", 64'(issue_rd), {54'd0, 5'd3, 5'd0});
        check("lu_interlock_hi", 64'(interlock), 64'd1);
        drive(32'd0, NOP_INST, NOP_INST);
        tick();
        check("lu_bubble_valid", 64'(issue_valid), 64'd0);
        check("lu_interlock_lo", 64'(interlock), 64'd0);
        tick();
        check("lu_add_valid", 64'(issue_valid), 64'h2);
        check("lu_add_pc", 64'(issue_pc), 64'd20);
        check("lu_add_rd", 64'(issue_rd), {54'd0, 5'd4, 5'd0});

        // intra-bundle RAW split
        drive(32'd8, enc(ADD, 5'd2, 5'd1, 5'd1), enc(ADD, 5'd5, 5'd2, 5'd0));
        tick();
        drive(32'd0, NOP_INST, NOP_INST);
        check("id_interlock_hi", 64'(interlock), 64'd1);
        tick();
        check("id_e1_valid", 64'(issue_valid), 64'h2);
        check("id_e1_pc", 64'(issue_pc), 64'd8);
        check("id_interlock_lo", 64'(interlock), 64'd0);
        tick();
        check("id_e2_valid", 64'(issue_valid), 64'h1);
        check("id_e2_pc", 64'(issue_pc), 64'd8);
        check("id_e2_rd_rs1", {44'd0, issue_rd, issue_rs1}, {44'd0, 5'd0, 5'd5, 5'd0, 5'd2});

        // WAW on the same rd splits too
        drive(32'd60, enc(ADD, 5'd11, 5'd1, 5'd1), enc(ADD, 5'd11, 5'd2, 5'd2));
        tick();
        drive(32'd0, NOP_INST, NOP_INST);
        tick();
        check("waw_e1_valid", 64'(issue_valid), 64'h2);
        tick();
        check("waw_e2_valid", 64'(issue_valid), 64'h1);
        check("waw_e2_rd", 64'(issue_rd), {54'd0, 5'd0, 5'd11});

        // rs2 field of a non-ALU op is not a read
        drive(32'd64, enc(ADD, 5'd12, 5'd1, 5'd1), enc(LD, 5'd13, 5'd2, 5'd12));
        tick();
        drive(32'd0, NOP_INST, NOP_INST);
        tick();
        check("rs2rule_valid", 64'(issue_valid), 64'h3);

        // store class does not write rd
        drive(32'd68, enc(ST, 5'd14, 5'd1, 5'd2), enc(ADD, 5'd14, 5'd1, 5'd2));
        tick();
        drive(32'd0, NOP_INST, NOP_INST);
        tick();
        check("store_valid", 64'(issue_valid), 64'h3);

        // flush while in SPLIT
        drive(32'd12, enc(ADD, 5'd6, 5'd1, 5'd2), enc(ADD, 5'd7, 5'd6, 5'd1));
        tick();
        drive(32'd0, NOP_INST, NOP_INST);
        tick();
        check("fl_split_valid", 64'(issue_valid), 64'h2);
        branch_flag = 1'b1;
        tick();
        branch_flag = 1'b0;
        check("fl_valid", 64'(issue_valid), 64'd0);
        check("fl_pc", 64'(issue_pc), 64'd0);
        check("fl_interlock", 64'(interlock), 64'd0);
        tick();
        check("fl_no_slot1", 64'(issue_valid), 64'd0);
        drive(32'd24, enc(ADD, 5'd1, 5'd2, 5'd3), enc(ADD, 5'd4, 5'd5, 5'd6));
        tick();
        drive(32'd0, NOP_INST, NOP_INST);
        tick();
        check("fl_run_valid", 64'(issue_valid), 64'h3);
        check("fl_run_pc", 64'(issue_pc), 64'd24);

        // r0 is never tracked
        drive(32'd28, enc(LD, 5'd0, 5'd1, 5'd0), NOP_INST);
        tick();
        drive(32'd32, enc(ADD, 5'd8, 5'd0, 5'd0), NOP_INST);
        tick();
        check("r0_ld_valid", 64'(issue_valid), 64'h2);
        check("r0_interlock", 64'(interlock), 64'd0);
        drive(32'd0, NOP_INST, NOP_INST);
        tick();
        check("r0_add_valid", 64'(issue_valid), 64'h2);
        check("r0_add_pc", 64'(issue_pc), 64'd32);

        // reset in the middle of a load-use stall
        drive(32'd36, enc(LD, 5'd3, 5'd1, 5'd0), NOP_INST);
        tick();
        drive(32'd40, enc(ADD, 5'd9, 5'd3, 5'd1), NOP_INST);
        tick();
        check("ms_interlock_hi", 64'(interlock), 64'd1);
        rst = 1'b1;
        drive(32'd0, NOP_INST, NOP_INST);
        tick();
        rst = 1'b0;
        check("ms_valid", 64'(issue_valid), 64'd0);
        check("ms_pc", 64'(issue_pc), 64'd0);
        check("ms_fields", {20'd0, issue_op, issue_rd, issue_rs1, issue_rs2}, 64'd0);
        check("ms_imm", 64'(issue_imm), 64'd0);
        check("ms_interlock", 64'(interlock), 64'd0);
        drive(32'd44, enc(ADD, 5'd10, 5'd3, 5'd3), NOP_INST);
        tick();
        check("ms_next_nostall", 64'(interlock), 64'd0);
        drive(32'd0, NOP_INST, NOP_INST);
        tick();
        check("ms_next_valid", 64'(issue_valid), 64'h2);
        check("ms_next_pc", 64'(issue_pc), 64'd44);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
